// File: rtl/axis_cobs_decode_if.sv
// 8-bit AXI-Stream bundle used on both sides of the COBS decoder.
// The master drives data, valid, last and user; the slave returns tready.
interface axis_cobs_decode_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_cobs_decode.sv
// COBS frame decoder: the 1-byte hold register delays each byte until its successor or the frame end is seen.
// Output lags input by one pushed byte. tready follows output-register space only, so it never stalls internally.
module axis_cobs_decode (
   input  logic                       clk,
   input  logic                       rst_n,
   axis_cobs_decode_if.slave          s_axis,
   axis_cobs_decode_if.master         m_axis
);

   typedef enum logic {ST_CODE, ST_DATA} state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       zero_pend_q, zero_pend_d;
   logic       in_frame_q, in_frame_d;
   logic [7:0] h_data_q, h_data_d;
   logic       h_valid_q, h_valid_d;
   logic       h_last_q, h_last_d;
   logic       h_user_q, h_user_d;
   logic [7:0] m_data_q, m_data_d;
   logic       m_valid_q, m_valid_d;
   logic       m_last_q, m_last_d;
   logic       m_user_q, m_user_d;

   logic       out_free;
   logic       accept;
   logic       slot_used;
   logic       do_push;
   logic [7:0] push_byte;
   logic       do_end;
   logic       frame_err;
   logic       end_bad;
   logic [7:0] fin_data;

   assign out_free       = !m_valid_q || m_axis.tready;
   assign s_axis.tready  = rst_n && out_free;
   assign accept         = s_axis.tvalid && s_axis.tready;

   assign m_axis.tdata   = m_data_q;
   assign m_axis.tvalid  = m_valid_q;
   assign m_axis.tlast   = m_last_q;
   assign m_axis.tuser   = m_user_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      zero_pend_d = zero_pend_q;
      in_frame_d  = in_frame_q;
      h_data_d    = h_data_q;
      h_valid_d   = h_valid_q;
      h_last_d    = h_last_q;
      h_user_d    = h_user_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      m_user_d    = m_user_q;
      slot_used   = 1'b0;
      do_push     = 1'b0;
      push_byte   = 8'h00;
      do_end      = 1'b0;
      frame_err   = 1'b0;
      end_bad     = 1'b0;
      fin_data    = 8'h00;

      if (out_free) begin
         m_valid_d = 1'b0;
      end

      // A frame that ended on a byte-pushing beat parks its last byte here; it
      // drains before the next frame can push, since a fresh frame's first beat never pushes.
      if (out_free && h_valid_q && h_last_q) begin
         m_data_d  = h_data_q;
         m_valid_d = 1'b1;
         m_last_d  = 1'b1;
         m_user_d  = h_user_q;
         h_valid_d = 1'b0;
         h_last_d  = 1'b0;
         slot_used = 1'b1;
      end

      if (accept) begin
         case (state_q)
            ST_CODE: begin
               if (s_axis.tdata == 8'h00) begin
                  do_end = in_frame_q;
               end else begin
                  do_push     = zero_pend_q;
                  cnt_d       = s_axis.tdata - 8'd1;
                  zero_pend_d = (s_axis.tdata != 8'hFF);
                  in_frame_d  = 1'b1;
                  state_d     = (s_axis.tdata > 8'h01) ? ST_DATA : ST_CODE;
                  if (s_axis.tlast) begin
                     do_end    = 1'b1;
                     frame_err = (s_axis.tdata > 8'h01);
                  end
               end
            end
            ST_DATA: begin
               if (s_axis.tdata == 8'h00) begin
                  do_end    = 1'b1;
                  frame_err = 1'b1;
               end else begin
                  do_push   = 1'b1;
                  push_byte = s_axis.tdata;
                  cnt_d     = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) begin
                     state_d = ST_CODE;
                  end
                  if (s_axis.tlast) begin
                     do_end    = 1'b1;
                     frame_err = (cnt_q != 8'd1);
                  end
               end
            end
            default: state_d = ST_CODE;
         endcase
      end

      if (do_push) begin
         if (h_valid_q && !h_last_q) begin
            m_data_d  = h_data_q;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            m_user_d  = 1'b0;
            slot_used = 1'b1;
         end
         h_data_d  = push_byte;
         h_valid_d = 1'b1;
         h_last_d  = 1'b0;
      end

      // If the output slot is already taken this cycle, the closing beat waits in the hold register.
      if (do_end) begin
         end_bad  = frame_err || s_axis.tuser;
         fin_data = h_valid_d ? h_data_d : 8'h00;
         if (h_valid_d || end_bad) begin
            if (slot_used) begin
               h_data_d  = fin_data;
               h_valid_d = 1'b1;
               h_last_d  = 1'b1;
               h_user_d  = end_bad;
            end else begin
               m_data_d  = fin_data;
               m_valid_d = 1'b1;
               m_last_d  = 1'b1;
               m_user_d  = end_bad;
               h_valid_d = 1'b0;
               h_last_d  = 1'b0;
            end
         end
         in_frame_d  = 1'b0;
         cnt_d       = 8'd0;
         zero_pend_d = 1'b0;
         state_d     = ST_CODE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CODE;
         cnt_q       <= 8'd0;
         zero_pend_q <= 1'b0;
         in_frame_q  <= 1'b0;
         h_data_q    <= 8'h00;
         h_valid_q   <= 1'b0;
         h_last_q    <= 1'b0;
         h_user_q    <= 1'b0;
         m_data_q    <= 8'h00;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_user_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         zero_pend_q <= zero_pend_d;
         in_frame_q  <= in_frame_d;
         h_data_q    <= h_data_d;
         h_valid_q   <= h_valid_d;
         h_last_q    <= h_last_d;
         h_user_q    <= h_user_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_user_q    <= m_user_d;
      end
   end

endmodule

// File: tb/tb_axis_cobs_decode.sv
// Bench for axis_cobs_decode: directed frames plus random COBS-encoded payloads,
// compared against expected decoded beats built from the raw payloads.
module tb_axis_cobs_decode;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axis_cobs_decode_if s_if();
   axis_cobs_decode_if m_if();

   axis_cobs_decode dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_axis (s_if),
      .m_axis (m_if)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   int    rdy_mode = 0;
   bit    gap_en   = 1'b0;
   bit    mon_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u);
      beat_t b;
      b.d = d;
      b.l = l;
      b.u = u;
      return b;
   endfunction

   // Downstream ready: 0 steady high, 1 toggle, 2 random, 3 held low.
   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            2:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      beat_t prev;
      beat_t cur;
      bit    stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         cur = mk(m_if.tdata, m_if.tlast, m_if.tuser);
         if (mon_en && stall) begin
            checks++;
            if (!m_if.tvalid || cur !== prev) begin
               failures++;
               $display("FAIL stall_stable got v=%b %h/%b/%b exp v=1 %h/%b/%b",
                        m_if.tvalid, cur.d, cur.l, cur.u, prev.d, prev.l, prev.u);
            end
         end
         stall = mon_en && m_if.tvalid && !m_if.tready;
         prev  = cur;
         if (m_if.tvalid && m_if.tready) got_q.push_back(cur);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
      int n;
      if (gap_en) begin
         s_if.tvalid = 1'b0;
         n = $urandom_range(0, 2);
         repeat (n) begin
            @(posedge clk);
            #1;
         end
      end
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tuser  = u;
      s_if.tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_if.tready && n < 1000) begin
         n++;
         @(negedge clk);
      end
      if (n >= 1000) begin
         checks++;
         failures++;
         $display("FAIL send_timeout tready stayed 0 for %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
   endtask

   task automatic wait_out();
      int k = 0;
      while (got_q.size() < exp_q.size() && k < 4000) begin
         @(posedge clk);
         k++;
      end
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'h00;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 5;
      if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
      if (m_if.tlast  !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_if.tlast); end
      if (m_if.tuser  !== 1'b0) begin failures++; $display("FAIL reset_tuser got=%b exp=0", m_if.tuser); end
      if (m_if.tdata  !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%h exp=00", m_if.tdata); end
      if (s_if.tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_if.tready); end
      rst_n = 1'b1;
      #1;
      checks++;
      if (s_if.tready !== 1'b1) begin failures++; $display("FAIL post_reset_tready got=%b exp=1", s_if.tready); end
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [7:0] enc[$];
      int c0;
      enc = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
      exp_q = '{mk(8'h11, 0, 0), mk(8'h22, 0, 0), mk(8'h00, 0, 0), mk(8'h33, 1, 0)};
      rdy_mode = 0;
      gap_en   = 1'b0;
      c0 = cyc;
      foreach (enc[i]) send_beat(enc[i], 1'b0, 1'b0);
      checks += 2;
      if (cyc - c0 != 6) begin failures++; $display("FAIL basic_throughput got=%0d cycles exp=6", cyc - c0); end
      if (!(m_if.tvalid && m_if.tlast && m_if.tdata == 8'h33)) begin
         failures++;
         $display("FAIL basic_last_latency got v=%b l=%b d=%h exp v=1 l=1 d=33", m_if.tvalid, m_if.tlast, m_if.tdata);
      end
      wait_out();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_ff_block();
      send_beat(8'hFF, 1'b0, 1'b0);
      for (int v = 1; v <= 254; v++) begin
         send_beat(8'(v), 1'b0, 1'b0);
         exp_q.push_back(mk(8'(v), v == 254, 1'b0));
      end
      send_beat(8'h01, 1'b1, 1'b0);
      wait_out();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ff_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ff_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_idle_zero();
      logic [7:0] enc[$];
      enc = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
      exp_q = '{mk(8'h00, 1, 0)};
      foreach (enc[i]) send_beat(enc[i], 1'b0, 1'b0);
      wait_out();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL idle_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL idle_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_errors();
      logic [7:0] enc[$];
      logic       lst[$];
      logic       usr[$];
      // truncated data group, truncated code-only frame, zero inside a group, upstream error flag
      enc = '{8'h04, 8'hAA, 8'hBB, 8'h05, 8'h03, 8'hAA, 8'h00, 8'h02, 8'hCC, 8'h00, 8'h02, 8'h77, 8'h00};
      lst = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      usr = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
      exp_q = '{mk(8'hAA, 0, 0), mk(8'hBB, 1, 1), mk(8'h00, 1, 1), mk(8'hAA, 1, 1),
                mk(8'hCC, 1, 0), mk(8'h77, 1, 1)};
      foreach (enc[i]) send_beat(enc[i], lst[i], usr[i]);
      wait_out();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL err_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL err_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stall();
      logic [7:0] enc[$];
      enc = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
      rdy_mode = 1;
      gap_en   = 1'b1;
      repeat (3) begin
         foreach (enc[i]) send_beat(enc[i], 1'b0, 1'b0);
         exp_q.push_back(mk(8'h11, 0, 0));
         exp_q.push_back(mk(8'h22, 0, 0));
         exp_q.push_back(mk(8'h00, 0, 0));
         exp_q.push_back(mk(8'h33, 1, 0));
      end
      wait_out();
      rdy_mode = 0;
      gap_en   = 1'b0;
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      rdy_mode = 3;
      repeat (2) @(posedge clk);
      #1;
      send_beat(8'h03, 1'b0, 1'b0);
      send_beat(8'h11, 1'b0, 1'b0);
      send_beat(8'h22, 1'b0, 1'b0);
      checks++;
      if (!(m_if.tvalid && m_if.tdata == 8'h11)) begin failures++; $display("FAIL midrst_pre got v=%b d=%h exp v=1 d=11", m_if.tvalid, m_if.tdata); end
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      checks += 2;
      if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid got=%b exp=0", m_if.tvalid); end
      if (s_if.tready !== 1'b0) begin failures++; $display("FAIL midrst_tready got=%b exp=0", s_if.tready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      mon_en   = 1'b1;
      rdy_mode = 0;
      send_beat(8'h02, 1'b0, 1'b0);
      send_beat(8'h55, 1'b0, 1'b0);
      send_beat(8'h00, 1'b0, 1'b0);
      exp_q = '{mk(8'h55, 1, 0)};
      wait_out();
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   // Random payloads, COBS-encoded here, delimited by 0x00 with optional idle fill.
   task automatic test_random();
      logic [7:0] raw[$];
      logic [7:0] enc[$];
      logic [7:0] blk[$];
      int len, zp, n;
      for (int f = 0; f < 30; f++) begin
         raw.delete(); enc.delete(); blk.delete();
         if ($urandom_range(0, 7) == 0) begin
            len = $urandom_range(250, 300);
            zp  = 1;
         end else begin
            len = $urandom_range(1, 24);
            zp  = 20;
         end
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 99) < zp) raw.push_back(8'h00);
            else                            raw.push_back(8'($urandom_range(1, 255)));
         end
         foreach (raw[i]) begin
            if (raw[i] == 8'h00) begin
               enc.push_back(8'(blk.size() + 1));
               foreach (blk[j]) enc.push_back(blk[j]);
               blk.delete();
            end else begin
               blk.push_back(raw[i]);
               if (blk.size() == 254) begin
                  enc.push_back(8'hFF);
                  foreach (blk[j]) enc.push_back(blk[j]);
                  blk.delete();
               end
            end
         end
         enc.push_back(8'(blk.size() + 1));
         foreach (blk[j]) enc.push_back(blk[j]);
         foreach (raw[i]) exp_q.push_back(mk(raw[i], i == raw.size() - 1, 1'b0));
         rdy_mode = $urandom_range(0, 2);
         gap_en   = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 2);
         repeat (n) send_beat(8'h00, 1'b0, 1'b0);
         foreach (enc[i]) send_beat(enc[i], 1'b0, 1'b0);
         send_beat(8'h00, 1'b0, 1'b0);
      end
      wait_out();
      rdy_mode = 0;
      gap_en   = 1'b0;
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_beat%0d got=%h/%b/%b exp=%h/%b/%b", i, got_q[i].d, got_q[i].l, got_q[i].u, exp_q[i].d, exp_q[i].l, exp_q[i].u); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ff_block();
      test_idle_zero();
      test_errors();
      test_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_cobs_decode.md
# axis_cobs_decode

Native COBS (Consistent Overhead Byte Stuffing) frame decoder on 8-bit AXI-Stream, the receive-side counterpart of the COBS encoder path. It accepts encoded frames terminated by a 0x00 delimiter and/or `tlast`, strips code bytes, and re-inserts the removed zeros. Decoded frames are emitted with `tlast` on the final byte and `tuser` flagging corrupt or truncated frames. It sits between a byte transport (UART/FIFO) and packet consumers.

## Interface
- Parameters: none; both stream data widths are fixed at 8 bits.
- `clk` in 1: single clock for both streams.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8: encoded byte.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input accept.
- `s_axis_tlast` in 1: end of encoded frame.
- `s_axis_tuser` in 1: upstream error; sampled on the frame-ending beat.
- `m_axis_tdata` out 8: decoded byte.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tlast` out 1: last decoded byte of the frame.
- `m_axis_tuser` out 1: frame bad; valid with `m_axis_tlast`, 0 on all other beats.

## Operation
- Registers:
  - `cnt` (8b): data bytes remaining in the current group.
  - `zero_pend`: the previous group had code < 0xFF.
  - `in_frame`
  - Hold register `h_data`/`h_valid`: one decoded byte, kept back so that `tlast` can be attached to it.
  - Output register `m_axis_*`.
- State CODE (expect a code byte C):
  - C=0x00, `in_frame`=0: idle fill; drop it.
  - C=0x00, `in_frame`=1: end of frame, good.
  - C≠0: if `zero_pend`, push 0x00. Then `cnt`=C−1, `zero_pend`=(C≠0xFF), `in_frame`=1. Go to DATA if C>1, otherwise stay in CODE.
  - `tlast` on a code beat ends the frame. C=0x01 or C=0x00 is a good end; C>1 is a truncation error.
- State DATA:
  - Nonzero byte: push it, decrement `cnt`; return to CODE when `cnt` reaches 0.
  - 0x00 byte: error end; the next byte starts a new frame.
  - `tlast` with `cnt`=1: good end.
  - `tlast` with `cnt`>1: error end.
- Push: if `h_valid`, move the held byte to the output register with `tlast`=0. Then load the new byte into the hold register.
- End of frame:
  - Discard `zero_pend`.
  - Move the held byte to the output with `tlast`=1 and `tuser`=error|`s_axis_tuser`.
  - If nothing is held and the frame is good, emit nothing.
  - If nothing is held and the frame has an error, emit a single 0x00 beat with `tlast`=1, `tuser`=1.
  - Clear `in_frame`, `cnt`, `h_valid`; state goes to CODE.
- Each accepted input moves at most one beat into the output register, so the block never stalls internally.

## Timing
- `s_axis_tready` = `rst_n` & (!`m_axis_tvalid` | `m_axis_tready`). This is combinational and has no dependency on `s_axis_tvalid`.
- Full throughput of 1 byte/cycle with `m_axis_tready`=1.
- Latency: a decoded byte appears on `m_axis` on the cycle after the *next* pushed byte or the frame end is accepted. The last byte appears 1 cycle after the terminating beat.
- Output beats hold stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- Reset values:
  - `m_axis_tvalid`/`tlast`/`tuser`/`tdata` = 0.
  - `s_axis_tready` = 0.
  - State CODE; `cnt`=0; `zero_pend`=`in_frame`=`h_valid`=0.
- Reset mid-frame: partial frame is discarded, `m_axis_tvalid` drops immediately, and the next byte is treated as a fresh frame start.
- Code 0xFF followed by exactly 254 data bytes inserts no zero. A code 0x01 that ends a frame yields no trailing zero.

## Test plan
- Input 03 11 22 02 33 00 → output 11 22 00 33; `tlast` on 33; `tuser`=0; throughput 1 byte/cycle.
- Input FF, 01..FE, then 01 with `tlast` → 254 bytes 01..FE, no inserted zero, `tlast` on FE, `tuser`=0.
- Input 00 00 01 01 00 → leading zeros dropped; single beat 00 with `tlast`=1, `tuser`=0.
- Input 04 AA BB with `tlast` on BB → AA BB, `tlast` on BB, `tuser`=1. Then input 03 AA 00 02 CC 00 → AA with `tlast`+`tuser`=1, followed by frame CC with `tlast`, `tuser`=0.
- Scenario 1 with `m_axis_tready` toggling every cycle, plus random `s_axis_tvalid` gaps → identical output bytes. No beat is dropped or duplicated, and `m_axis_tdata` is stable while stalled.
- Assert `rst_n`=0 after 03 11 is accepted → `m_axis_tvalid`=0 at once. Then input 02 55 00 → single beat 55 with `tlast`, `tuser`=0.
